// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: per-register pending-latency scoreboard, HI/LO occupancy and E-stage forwarding.
// Optional stall statistics counter is enabled by defining HAZARD_STALL_STATS_EN.
module hazard_scoreboard #(
  parameter int NREG       = 32,
  parameter int RAW        = 5,
  parameter int LOAD_STALL = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic           valid_D,
  input  logic [RAW-1:0] rs_D,
  input  logic [RAW-1:0] rt_D,
  input  logic           use_rs_D,
  input  logic           use_rt_D,
  input  logic           wr_en_D,
  input  logic [RAW-1:0] wr_reg_D,
  input  logic           is_load_D,
  input  logic           is_muldiv_D,
  input  logic           reads_hilo_D,
  input  logic           branch_taken,
  input  logic           RegWrite_M,
  input  logic           RegWrite_W,
  input  logic [RAW-1:0] WriteReg_M,
  input  logic [RAW-1:0] WriteReg_W,
  input  logic [RAW-1:0] Rs_E,
  input  logic [RAW-1:0] Rt_E,
  output logic [1:0]     ForwardA_E,
  output logic [1:0]     ForwardB_E,
  output logic           Stall_F,
  output logic           Stall_D,
  output logic           Flush_D,
  output logic           Flush_E,
  output logic           muldiv_busy,
  output logic [31:0]    stall_cycles
);

  if ((LOAD_STALL < 1) || (LOAD_STALL > 7)) begin : gBadLoadStall
    $error("hazard_scoreboard: LOAD_STALL must lie in 1..7");
  end
  if ((MULDIV_LAT < 1) || (MULDIV_LAT > 63)) begin : gBadMuldivLat
    $error("hazard_scoreboard: MULDIV_LAT must lie in 1..63");
  end

  localparam logic [2:0] LOAD_SET = 3'(LOAD_STALL);
  localparam logic [5:0] HILO_SET = 6'(MULDIV_LAT);

  logic [2:0] pendCnt [1:NREG-1];
  logic [5:0] hiloCnt;
  logic [2:0] pendRs;
  logic [2:0] pendRt;
  logic       hazard;
  logic       stall;
  logic       issue;

  function automatic logic [1:0] fwdSel(
    input logic [RAW-1:0] src,
    input logic           wrM,
    input logic [RAW-1:0] regM,
    input logic           wrW,
    input logic [RAW-1:0] regW
  );
    logic [1:0] sel;
    if (wrM && (regM != {RAW{1'b0}}) && (regM == src)) begin
      sel = 2'b01;
    end else if (wrW && (regW != {RAW{1'b0}}) && (regW == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Register 0 has no stored count, so its lookup is forced to zero.
  always_comb begin
    pendRs = 3'd0;
    pendRt = 3'd0;
    if (rs_D != {RAW{1'b0}}) begin
      pendRs = pendCnt[rs_D];
    end else begin
      pendRs = 3'd0;
    end
    if (rt_D != {RAW{1'b0}}) begin
      pendRt = pendCnt[rt_D];
    end else begin
      pendRt = 3'd0;
    end
    hazard = valid_D & ((use_rs_D & (pendRs != 3'd0)) |
                        (use_rt_D & (pendRt != 3'd0)) |
                        ((reads_hilo_D | is_muldiv_D) & (hiloCnt != 6'd0)));
    stall  = hazard & ~branch_taken;
    issue  = valid_D & ~stall & ~branch_taken;
  end

  assign Stall_F     = stall;
  assign Stall_D     = stall;
  assign Flush_E     = stall;
  assign Flush_D     = branch_taken;
  assign muldiv_busy = (hiloCnt != 6'd0);
  assign ForwardA_E  = fwdSel(Rs_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);
  assign ForwardB_E  = fwdSel(Rt_E, RegWrite_M, WriteReg_M, RegWrite_W, WriteReg_W);

  // A GPR write issued this cycle overrides the decrement: loads arm the count, ALU ops cancel it.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) begin
        pendCnt[r] <= 3'd0;
      end
      hiloCnt <= 6'd0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (issue && wr_en_D && (wr_reg_D == RAW'(r))) begin
          pendCnt[r] <= is_load_D ? LOAD_SET : 3'd0;
        end else if (pendCnt[r] != 3'd0) begin
          pendCnt[r] <= pendCnt[r] - 3'd1;
        end
      end
      if (issue && is_muldiv_D) begin
        hiloCnt <= HILO_SET;
      end else if (hiloCnt != 6'd0) begin
        hiloCnt <= hiloCnt - 6'd1;
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] stallCnt;

  // Free-running count of stalled cycles, wrapping naturally at 2^32.
  always_ff @(posedge CLK) begin
    if (reset) begin
      stallCnt <= 32'd0;
    end else if (stall) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end

  assign stall_cycles = stallCnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule
